// File: rtl/alu_li.sv
// alu_li: latency-insensitive binary32 add/multiply leaf.
// One operation in flight; operands enter through a valid/ready channel,
// the result leaves through a valid/ready channel after ADD_S or MUL_S cycles.
// Subnormal inputs are read as signed zero and subnormal results flush to
// signed zero; rounding is round-to-nearest-even; any NaN becomes 0x7FC00000.

module alu_li #(
    parameter int WIDTH = 32,
    parameter int ADD_S = 2,
    parameter int MUL_S = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             op_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] result_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int MAX_S = (ADD_S > MUL_S) ? ADD_S : MUL_S;
    localparam int CNT_W = $clog2(MAX_S + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               accept_s;
    logic               finish_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               op_r;
    logic [WIDTH-1:0]   fp_res_s;
    logic               ready_r;
    logic               valid_r;
    logic [WIDTH-1:0]   result_r;

    // True for an exponent of all ones with a non-zero fraction.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Leading-zero count of a 27-bit vector (27 when the vector is zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // binary32 addition with guard/round/sticky alignment and RNE rounding.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               sa, sb, sl, ss, sticky, rnd;
        logic [7:0]         ea, eb, el, es, d;
        logic [22:0]        fa, fb;
        logic [23:0]        ml, ms;
        logic [26:0]        mlx, msx_full, msx, mask, norm;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic signed [11:0] ex;
        logic [24:0]        mr;
        logic [31:0]        res;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        sl = 1'b0; ss = 1'b0; el = 8'd0; es = 8'd0; d = 8'd0;
        ml = 24'd0; ms = 24'd0; mlx = 27'd0; msx_full = 27'd0; msx = 27'd0;
        mask = 27'd0; norm = 27'd0; sum = 28'd0; lz = 5'd0; ex = 12'sd0;
        mr = 25'd0; sticky = 1'b0; rnd = 1'b0; res = 32'd0;
        if (is_nan(a) || is_nan(b)) begin
            res = QNAN;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            res = (sa != sb) ? QNAN : {sa, 8'hFF, 23'd0};
        end else if (ea == 8'hFF) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (eb == 8'hFF) begin
            res = {sb, 8'hFF, 23'd0};
        end else if (ea == 8'd0 && eb == 8'd0) begin
            // Only (-0)+(-0) keeps the minus sign.
            res = {sa & sb, 31'd0};
        end else if (ea == 8'd0) begin
            res = b;
        end else if (eb == 8'd0) begin
            res = a;
        end else begin
            // Order by magnitude so the subtraction below never goes negative.
            if ({ea, fa} >= {eb, fb}) begin
                sl = sa; el = ea; ml = {1'b1, fa};
                ss = sb; es = eb; ms = {1'b1, fb};
            end else begin
                sl = sb; el = eb; ml = {1'b1, fb};
                ss = sa; es = ea; ms = {1'b1, fa};
            end
            d        = el - es;
            mlx      = {ml, 3'b000};
            msx_full = {ms, 3'b000};
            if (d >= 8'd27) begin
                msx = 27'd1;
            end else begin
                mask   = (27'd1 << d) - 27'd1;
                sticky = |(msx_full & mask);
                msx    = (msx_full >> d) | {26'd0, sticky};
            end
            if (sl ^ ss) begin
                sum = {1'b0, mlx} - {1'b0, msx};
            end else begin
                sum = {1'b0, mlx} + {1'b0, msx};
            end
            if (sum == 28'd0) begin
                // Exact cancellation always yields +0.
                res = 32'd0;
            end else begin
                if (sum[27]) begin
                    norm = sum[27:1] | {26'd0, sum[0]};
                    ex   = $signed({4'd0, el}) + 12'sd1;
                end else begin
                    lz   = lzc27(sum[26:0]);
                    norm = sum[26:0] << lz;
                    ex   = $signed({4'd0, el}) - $signed({7'd0, lz});
                end
                rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
                mr  = {1'b0, norm[26:3]} + {24'd0, rnd};
                if (mr[24]) begin
                    mr = mr >> 1;
                    ex = ex + 12'sd1;
                end else begin
                    mr = mr;
                end
                if (ex >= 12'sd255) begin
                    res = {sl, 8'hFF, 23'd0};
                end else if (ex <= 12'sd0) begin
                    res = {sl, 31'd0};
                end else begin
                    res = {sl, ex[7:0], mr[22:0]};
                end
            end
        end
        return res;
    endfunction

    // binary32 multiplication: 24x24 product, normalise, RNE rounding.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               sgn, g, st, rnd;
        logic [7:0]         ea, eb;
        logic [47:0]        p;
        logic [23:0]        mm;
        logic signed [11:0] ex;
        logic [24:0]        mr;
        logic [31:0]        res;
        sgn = a[31] ^ b[31];
        ea  = a[30:23];
        eb  = b[30:23];
        p = 48'd0; mm = 24'd0; g = 1'b0; st = 1'b0; rnd = 1'b0;
        ex = 12'sd0; mr = 25'd0; res = 32'd0;
        if (is_nan(a) || is_nan(b)) begin
            res = QNAN;
        end else if (ea == 8'hFF) begin
            res = (eb == 8'd0) ? QNAN : {sgn, 8'hFF, 23'd0};
        end else if (eb == 8'hFF) begin
            res = (ea == 8'd0) ? QNAN : {sgn, 8'hFF, 23'd0};
        end else if (ea == 8'd0 || eb == 8'd0) begin
            res = {sgn, 31'd0};
        end else begin
            p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            ex = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd127;
            if (p[47]) begin
                mm = p[47:24];
                g  = p[23];
                st = |p[22:0];
                ex = ex + 12'sd1;
            end else begin
                mm = p[46:23];
                g  = p[22];
                st = |p[21:0];
            end
            rnd = g & (st | mm[0]);
            mr  = {1'b0, mm} + {24'd0, rnd};
            if (mr[24]) begin
                mr = mr >> 1;
                ex = ex + 12'sd1;
            end else begin
                mr = mr;
            end
            if (ex >= 12'sd255) begin
                res = {sgn, 8'hFF, 23'd0};
            end else if (ex <= 12'sd0) begin
                res = {sgn, 31'd0};
            end else begin
                res = {sgn, ex[7:0], mr[22:0]};
            end
        end
        return res;
    endfunction

    // Next-state and counter logic of the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_in && ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_BUSY;
                    cnt_next_s   = op_in ? CNT_W'(MUL_S) : CNT_W'(ADD_S);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r <= CNT_W'(1)) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                    cnt_next_s   = CNT_W'(0);
                end else begin
                    cnt_next_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (ready_in) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_W'(0);
            end
        endcase
    end

    // Arithmetic result from the latched operands; only sampled on expiry.
    always_comb begin
        fp_res_s = op_r ? fp_mul(a_r, b_r) : fp_add(a_r, b_r);
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Operand capture at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= 1'b0;
        end else if (accept_s) begin
            a_r  <= a_in;
            b_r  <= b_in;
            op_r <= op_in;
        end else begin
            op_r <= op_r;
        end
    end

    // Registered handshake outputs and result, derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            result_r <= '0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            valid_r <= (state_next_s == ST_DONE);
            if (finish_s) begin
                result_r <= fp_res_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign ready_out  = ready_r;
    assign valid_out  = valid_r;
    assign result_out = result_r;

endmodule

// File: tb/tb_alu_li.sv
// Scoreboard bench for alu_li: the stimulus process pushes hand-computed
// results and due cycles; a negedge monitor pops and compares on valid_out.

module tb_alu_li;

    localparam int WIDTH = 32;
    localparam int ADD_S = 2;
    localparam int MUL_S = 2;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             op_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] result_out;
    logic             valid_out;
    logic             ready_in;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    logic [31:0] exp_q[$];
    int          due_q[$];

    alu_li #(.WIDTH(WIDTH), .ADD_S(ADD_S), .MUL_S(MUL_S)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_in      (op_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .result_out (result_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] req);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_ready: got 0 expected 1");
        end else begin
            a_in     = a;
            b_in     = b;
            op_in    = op;
            valid_in = 1'b1;
            @(posedge clk);
            #1;
            exp_q.push_back(req);
            due_q.push_back(cyc + (op ? MUL_S : ADD_S));
            valid_in = 1'b0;
            a_in     = ~a;
            b_in     = ~b;
            op_in    = ~op;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_out) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: compare result and latency on each new valid, check hold and release.
    initial begin
        logic        seen;
        logic        xfer_pend;
        logic [31:0] held;
        logic [31:0] e;
        int          dcy;
        seen = 1'b0;
        xfer_pend = 1'b0;
        held = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (xfer_pend) begin
                    chk("post_xfer_valid", 32'(valid_out), 32'd0);
                    chk("post_xfer_ready", 32'(ready_out), 32'd1);
                    xfer_pend = 1'b0;
                end
                if (valid_out) begin
                    chk("ready_low_while_valid", 32'(ready_out), 32'd0);
                    if (!seen) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_valid: got %h expected none", result_out);
                        end else begin
                            e   = exp_q.pop_front();
                            dcy = due_q.pop_front();
                            chk("result", result_out, e);
                            chk("latency_cycle", 32'(cyc), 32'(dcy));
                        end
                        seen = 1'b1;
                        held = result_out;
                    end else begin
                        chk("result_hold", result_out, held);
                    end
                    if (ready_in) begin
                        xfer_pend = 1'b1;
                        seen      = 1'b0;
                    end
                end else begin
                    seen = 1'b0;
                end
            end else begin
                seen      = 1'b0;
                xfer_pend = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int n;
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        a_in     = 32'd0;
        b_in     = 32'd0;
        op_in    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;

        @(negedge clk);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_result", result_out, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready_out), 32'd1);
        chk("post_rst_valid", 32'(valid_out), 32'd0);
        chk("post_rst_result", result_out, 32'd0);

        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000); drain();
        issue(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4000_0000); drain();
        issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000); drain();
        issue(32'h7F7F_FFFF, 32'h4000_0000, 1'b1, 32'h7F80_0000); drain();
        issue(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000); drain();
        issue(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002); drain();
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000); drain();
        issue(32'h3F80_0000, 32'hBF7F_FFFF, 1'b0, 32'h3380_0000); drain();
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000); drain();
        issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000); drain();
        issue(32'h7F80_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000); drain();
        issue(32'hC000_0000, 32'h4040_0000, 1'b1, 32'hC0C0_0000); drain();
        issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h4010_0000); drain();
        issue(32'h0080_0000, 32'h0080_0000, 1'b1, 32'h0000_0000); drain();
        issue(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000); drain();
        issue(32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000); drain();
        issue(32'h4040_0000, 32'hBF80_0000, 1'b0, 32'h4000_0000); drain();

        // Back-pressure: hold ready_in low for five cycles after valid_out.
        @(posedge clk);
        #1 ready_in = 1'b0;
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        n = 0;
        while (!valid_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(valid_out), 32'd1);
        repeat (5) @(posedge clk);
        chk("bp_valid_held", 32'(valid_out), 32'd1);
        chk("bp_ready_low", 32'(ready_out), 32'd0);
        chk("bp_result_held", result_out, 32'h4040_0000);
        #1 ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_drop", 32'(valid_out), 32'd0);
        chk("bp_ready_rise", 32'(ready_out), 32'd1);
        drain();

        // Reset during BUSY aborts the operation without emitting a result.
        issue(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
        @(negedge clk);
        reset = 1'b0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            void'(due_q.pop_back());
        end
        @(negedge clk);
        chk("abort_ready", 32'(ready_out), 32'd1);
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_result", result_out, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_valid", 32'(valid_out), 32'd0);
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000); drain();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
